bfis_expand_sched: RTL and testbench
====================================

// Module: bfis_expand_sched
// PURPOSE
//  Sequencer for the bfis best-first search core. Walks the graph one expansion at a time:
//  reads a vertex's adjacency list from the graph BRAM and streams the neighbour ids into the
//  core over its vertex/vertex_addr/vertex_valid inputs. It then waits for the core to name the
//  next vertex to expand, or to report convergence. Sits between the graph memory and bfis.
// PARAMETERS
//  MAX_DEG      8   max neighbours per vertex; list stride in memory is MAX_DEG+1 words
//  MEM_LATENCY  2   cycles from mem_ren_out to mem_data_in valid (fixed, >=1)
//  MAX_HOPS     64  expansion limit per search (>=1, <=65535)
//  LIST_BASE    0   word address of vertex 0's adjacency list
// PORTS
//  clk_in            in   1   system clock
//  rst_in            in   1   asynchronous, active-low reset
//  start_in          in   1   begin search; sampled only in IDLE
//  entry_in          in   32  entry vertex id, latched with start_in
//  busy_out          out  1   high in every state except IDLE
//  done_out          out  1   one-cycle pulse on search end
//  limit_hit_out     out  1   search ended on MAX_HOPS; held until next start
//  hops_out          out  16  expansions completed in the current/last search
//  mem_addr_out      out  32  graph memory read address
//  mem_ren_out       out  1   read strobe, one word per cycle
//  mem_data_in       in   32  read data, MEM_LATENCY cycles after strobe
//  vertex_out        out  32  neighbour id to core
//  vertex_addr_out   out  32  id of vertex being expanded (parent)
//  vertex_valid_out  out  1   vertex_out/vertex_addr_out valid, one-cycle per neighbour
//  expand_ready_out  out  1   scheduler waiting for next expansion (NEXT state)
//  expand_valid_in   in   1   core offers next vertex
//  expand_id_in      in   32  next vertex id
//  converged_in      in   1   core reports search complete
// BEHAVIOUR
//  Reset (rst_in=0, async): state IDLE; all outputs 0; in-flight read pipeline cleared.
//  base = LIST_BASE + cur_id*(MAX_DEG+1), 32-bit, wraps mod 2^32; word base = degree,
//  words base+1..base+deg = neighbour ids.
//  IDLE: start_in -> cur_id=entry_in, hops=0, limit_hit=0, -> HDR.
//  HDR: mem_ren_out=1, mem_addr_out=base, one cycle -> WAIT_HDR.
//  WAIT_HDR: MEM_LATENCY cycles after HDR read, capture deg=min(mem_data_in,MAX_DEG);
//    deg==0 -> hops++ -> NEXT; else -> STREAM.
//  STREAM: issue reads base+1..base+deg back-to-back, one per cycle; after last -> DRAIN.
//  Every issued neighbour read returns MEM_LATENCY cycles later and is emitted that same cycle
//    (vertex_valid_out=1, vertex_out=mem_data_in, vertex_addr_out=cur_id); tracked by a
//    MEM_LATENCY-deep valid shift register.
//  DRAIN: wait until shift register empty; hops++ -> NEXT.
//  NEXT: hops==MAX_HOPS -> DONE, limit_hit=1. Else expand_ready_out=1;
//    converged_in -> DONE (wins over expand_valid_in in the same cycle);
//    expand_valid_in -> cur_id=expand_id_in -> HDR.
//  DONE: done_out=1 for one cycle -> IDLE. hops_out/limit_hit_out hold until next start.
//  start_in ignored while busy_out=1. converged_in/expand_valid_in ignored outside NEXT.
//  Reset mid-operation: returns to IDLE immediately; discarded reads never emit vertex_valid_out.
//  Throughput: one neighbour per cycle; expansion latency = 2*MEM_LATENCY+deg+2 cycles.
// TESTING
//  1. entry=3, mem[27]=2, mem[28]=10, mem[29]=11 -> reads 27,28,29; vertex_out 10 then 11 on
//     consecutive cycles, vertex_addr_out=3; expand_ready_out high after drain, hops_out=1.
//  2. In NEXT, converged_in=1 and expand_valid_in=1 together -> done_out pulse, no new HDR read,
//     hops_out=1, limit_hit_out=0.
//  3. Header degree 12 -> exactly 8 neighbour reads/emissions, then NEXT.
//  4. Header degree 0 -> no vertex_valid_out, hops_out increments, expand_ready_out asserts.
//  5. MAX_HOPS=2, core always answers expand_valid_in -> done_out after 2nd expansion,
//     limit_hit_out=1, hops_out=2; start_in during search ignored.
//  6. rst_in low mid-STREAM with 2 reads in flight -> all outputs 0 at once; after release
//     no vertex_valid_out appears; new start_in runs cleanly.

Source files
------------

// File: rtl/bfis_expand_sched.sv
// Expansion sequencer for bfis: fetches a vertex's adjacency list and streams its neighbours to the core, then waits for the next expansion.
// Latency 2*MEM_LATENCY+deg+2 cycles per expansion; the neighbour stream has no backpressure, and the core paces the search via expand_valid_in.
module bfis_expand_sched #(
  parameter int          MAX_DEG     = 8,
  parameter int          MEM_LATENCY = 2,
  parameter int          MAX_HOPS    = 64,
  parameter logic [31:0] LIST_BASE   = 32'd0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic [31:0] entry_in,
  output logic        busy_out,
  output logic        done_out,
  output logic        limit_hit_out,
  output logic [15:0] hops_out,
  output logic [31:0] mem_addr_out,
  output logic        mem_ren_out,
  input  logic [31:0] mem_data_in,
  output logic [31:0] vertex_out,
  output logic [31:0] vertex_addr_out,
  output logic        vertex_valid_out,
  output logic        expand_ready_out,
  input  logic        expand_valid_in,
  input  logic [31:0] expand_id_in,
  input  logic        converged_in
);

  localparam int DW = (MAX_DEG > 1) ? $clog2(MAX_DEG + 1) : 1;
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] HDR_LAST = CW'(MEM_LATENCY - 1);
  localparam logic [DW-1:0] DEG_MAX  = DW'(MAX_DEG);
  localparam logic [31:0]   STRIDE   = 32'(MAX_DEG + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_WAIT_HDR,
    S_STREAM,
    S_DRAIN,
    S_NEXT,
    S_DONE
  } state_t;

  state_t                 state, state_nxt;
  logic [31:0]            cur_id;
  logic [DW-1:0]          deg;
  logic [DW-1:0]          idx;
  logic [CW-1:0]          wcnt;
  logic [MEM_LATENCY-1:0] rd_sr;
  logic [MEM_LATENCY:0]   rd_sr_cat;
  logic [15:0]            hops;
  logic                   limit_hit;

  logic [31:0]   base;
  logic [DW-1:0] hdr_deg;
  logic          hdr_cap;
  logic          issue;
  logic          inc_hops;
  logic          set_limit;
  logic          load_next;
  logic          emit;

  // Address arithmetic deliberately truncates to 32 bits.
  assign base    = LIST_BASE + cur_id * STRIDE;
  assign hdr_deg = (mem_data_in > 32'(MAX_DEG)) ? DEG_MAX : mem_data_in[DW-1:0];
  assign emit    = rd_sr[MEM_LATENCY-1];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    mem_ren_out      = 1'b0;
    mem_addr_out     = 32'd0;
    expand_ready_out = 1'b0;
    done_out         = 1'b0;
    hdr_cap          = 1'b0;
    issue            = 1'b0;
    inc_hops         = 1'b0;
    set_limit        = 1'b0;
    load_next        = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_in) state_nxt = S_HDR;
      end
      S_HDR: begin
        mem_ren_out  = 1'b1;
        mem_addr_out = base;
        state_nxt    = S_WAIT_HDR;
      end
      S_WAIT_HDR: begin
        if (wcnt == HDR_LAST) begin
          hdr_cap = 1'b1;
          if (hdr_deg == '0) begin
            inc_hops  = 1'b1;
            state_nxt = S_NEXT;
          end else begin
            state_nxt = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        mem_ren_out  = 1'b1;
        mem_addr_out = base + 32'(idx);
        issue        = 1'b1;
        if (idx == deg) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (rd_sr == '0) begin
          inc_hops  = 1'b1;
          state_nxt = S_NEXT;
        end
      end
      S_NEXT: begin
        if (hops == 16'(MAX_HOPS)) begin
          set_limit = 1'b1;
          state_nxt = S_DONE;
        end else begin
          expand_ready_out = 1'b1;
          // Convergence takes priority over a simultaneous expansion offer.
          if (converged_in) begin
            state_nxt = S_DONE;
          end else if (expand_valid_in) begin
            load_next = 1'b1;
            state_nxt = S_HDR;
          end
        end
      end
      S_DONE: begin
        done_out  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign rd_sr_cat = {rd_sr, issue};

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cur_id    <= 32'd0;
      deg       <= '0;
      idx       <= '0;
      wcnt      <= '0;
      rd_sr     <= '0;
      hops      <= 16'd0;
      limit_hit <= 1'b0;
    end else begin
      rd_sr <= rd_sr_cat[MEM_LATENCY-1:0];
      if (state == S_IDLE && start_in) begin
        cur_id    <= entry_in;
        hops      <= 16'd0;
        limit_hit <= 1'b0;
      end
      if (load_next) cur_id <= expand_id_in;
      if (state == S_HDR) wcnt <= '0;
      else if (state == S_WAIT_HDR) wcnt <= wcnt + 1'b1;
      if (hdr_cap) begin
        deg <= hdr_deg;
        idx <= DW'(1);
      end else if (issue) begin
        idx <= idx + 1'b1;
      end
      if (inc_hops)  hops      <= hops + 16'd1;
      if (set_limit) limit_hit <= 1'b1;
    end
  end

  assign busy_out         = (state != S_IDLE);
  assign limit_hit_out    = limit_hit;
  assign hops_out         = hops;
  assign vertex_valid_out = emit;
  assign vertex_out       = emit ? mem_data_in : 32'd0;
  assign vertex_addr_out  = emit ? cur_id : 32'd0;

endmodule

// File: tb/tb_bfis_expand_sched.sv
// Directed bench for bfis_expand_sched with a MEM_LATENCY=2 graph memory model and MAX_HOPS=2.
module tb_bfis_expand_sched;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start_in;
  logic [31:0] entry_in;
  logic        busy_out;
  logic        done_out;
  logic        limit_hit_out;
  logic [15:0] hops_out;
  logic [31:0] mem_addr_out;
  logic        mem_ren_out;
  logic [31:0] mem_data_in;
  logic [31:0] vertex_out;
  logic [31:0] vertex_addr_out;
  logic        vertex_valid_out;
  logic        expand_ready_out;
  logic        expand_valid_in;
  logic [31:0] expand_id_in;
  logic        converged_in;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int ready_cyc;

  logic [31:0] mem [256];
  logic [31:0] d1, d2;

  int rd_addr[$];
  int rd_cyc[$];
  int em_v[$];
  int em_p[$];
  int em_cyc[$];

  bfis_expand_sched #(
    .MAX_DEG(8), .MEM_LATENCY(2), .MAX_HOPS(2), .LIST_BASE(32'd0)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .entry_in(entry_in),
    .busy_out(busy_out), .done_out(done_out), .limit_hit_out(limit_hit_out),
    .hops_out(hops_out), .mem_addr_out(mem_addr_out), .mem_ren_out(mem_ren_out),
    .mem_data_in(mem_data_in), .vertex_out(vertex_out), .vertex_addr_out(vertex_addr_out),
    .vertex_valid_out(vertex_valid_out), .expand_ready_out(expand_ready_out),
    .expand_valid_in(expand_valid_in), .expand_id_in(expand_id_in),
    .converged_in(converged_in)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    d1  <= mem_ren_out ? mem[mem_addr_out[7:0]] : 32'd0;
    d2  <= d1;
  end
  assign mem_data_in = d2;

  always @(negedge clk_in) begin
    if (mem_ren_out) begin
      rd_addr.push_back(int'(mem_addr_out));
      rd_cyc.push_back(cyc);
    end
    if (vertex_valid_out) begin
      em_v.push_back(int'(vertex_out));
      em_p.push_back(int'(vertex_addr_out));
      em_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_in);
    #2;
  endtask

  task automatic clear_logs();
    rd_addr = {}; rd_cyc = {}; em_v = {}; em_p = {}; em_cyc = {};
  endtask

  task automatic start_search(input logic [31:0] e);
    clear_logs();
    entry_in = e;
    start_in = 1'b1;
    step();
    start_in = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      step();
      if (expand_ready_out) begin
        ok = 1'b1;
        ready_cyc = cyc;
      end
    end
    check({tag, "_ready_seen"}, ok, 1);
  endtask

  task automatic check_run(input string tag, input int rbase, input int n_rd,
                           input int efirst, input int n_em, input int parent);
    check({tag, "_n_reads"}, rd_addr.size(), n_rd);
    for (int i = 0; i < n_rd; i++)
      check({tag, "_rd_addr"}, (i < rd_addr.size()) ? rd_addr[i] : -1, rbase + i);
    check({tag, "_n_emit"}, em_v.size(), n_em);
    for (int i = 0; i < n_em; i++) begin
      check({tag, "_emit_val"}, (i < em_v.size()) ? em_v[i] : -1, efirst + i);
      check({tag, "_emit_parent"}, (i < em_p.size()) ? em_p[i] : -1, parent);
      if (i > 0 && i < em_cyc.size())
        check({tag, "_emit_b2b"}, em_cyc[i] - em_cyc[i-1], 1);
    end
  endtask

  task automatic converge_done(input string tag);
    converged_in = 1'b1;
    step();
    converged_in = 1'b0;
    check({tag, "_done_pulse"}, done_out, 1);
    step();
    check({tag, "_done_cleared"}, {busy_out, done_out}, 2'b00);
  endtask

  initial begin
    bit ok;
    bit saw_ready;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[27] = 32'd2;  mem[28] = 32'd10; mem[29] = 32'd11;
    mem[45] = 32'd12;
    for (int i = 0; i < 12; i++) mem[46 + i] = 32'(100 + i);
    mem[63] = 32'd0;
    mem[90] = 32'd1;  mem[91] = 32'd20;
    mem[99] = 32'd0;

    rst_in = 1'b0; start_in = 1'b0; entry_in = 32'd0;
    expand_valid_in = 1'b0; expand_id_in = 32'd0; converged_in = 1'b0;
    step(); step();
    check("reset_outputs",
          {busy_out, done_out, limit_hit_out, hops_out, mem_addr_out, mem_ren_out,
           vertex_out, vertex_addr_out, vertex_valid_out, expand_ready_out}, '0);
    rst_in = 1'b1;
    step();

    // Two-neighbour vertex 3: list at 27.
    start_search(32'd3);
    check("t1_busy", busy_out, 1);
    wait_ready("t1");
    check_run("t1", 27, 3, 10, 2, 3);
    check("t1_hops", hops_out, 1);
    check("t1_latency", ready_cyc - ((rd_cyc.size() > 0) ? rd_cyc[0] : 0), 8);

    // Convergence and an expansion offer in the same cycle.
    converged_in = 1'b1; expand_valid_in = 1'b1; expand_id_in = 32'd7;
    step();
    converged_in = 1'b0; expand_valid_in = 1'b0;
    check("t2_done_pulse", done_out, 1);
    step();
    step();
    check("t2_no_new_read", rd_addr.size(), 3);
    check("t2_idle", {busy_out, done_out}, 2'b00);
    check("t2_hops", hops_out, 1);
    check("t2_limit", limit_hit_out, 0);

    // Header degree 12 clamps to 8 reads and emissions.
    start_search(32'd5);
    wait_ready("t3");
    check_run("t3", 45, 9, 100, 8, 5);
    check("t3_hops", hops_out, 1);
    check("t3_latency", ready_cyc - ((rd_cyc.size() > 0) ? rd_cyc[0] : 0), 14);
    converge_done("t3");

    // Degree 0: header read only.
    start_search(32'd7);
    wait_ready("t4");
    check_run("t4", 63, 1, 0, 0, 7);
    check("t4_hops", hops_out, 1);
    converge_done("t4");

    // Hop limit of 2 with a start pulse ignored while busy.
    start_search(32'd10);
    wait_ready("t5");
    check_run("t5", 90, 2, 20, 1, 10);
    expand_valid_in = 1'b1; expand_id_in = 32'd11;
    step();
    expand_valid_in = 1'b0;
    entry_in = 32'd3; start_in = 1'b1;
    step();
    start_in = 1'b0;
    ok = 1'b0; saw_ready = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      step();
      if (expand_ready_out) saw_ready = 1'b1;
      if (done_out) ok = 1'b1;
    end
    check("t5_done_seen", ok, 1);
    check("t5_no_ready_at_limit", saw_ready, 0);
    check("t5_limit", limit_hit_out, 1);
    check("t5_hops", hops_out, 2);
    check("t5_n_reads", rd_addr.size(), 3);
    check("t5_rd_second_hdr", (rd_addr.size() > 2) ? rd_addr[2] : -1, 99);
    step();
    check("t5_hold", {busy_out, limit_hit_out, hops_out}, {1'b0, 1'b1, 16'd2});

    // Reset while neighbour reads are in flight.
    start_search(32'd5);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      step();
      if (mem_ren_out && mem_addr_out == 32'd48) ok = 1'b1;
    end
    check("t6_reached_stream", ok, 1);
    rst_in = 1'b0;
    #1;
    check("t6_reset_outputs",
          {busy_out, done_out, limit_hit_out, hops_out, mem_addr_out, mem_ren_out,
           vertex_out, vertex_addr_out, vertex_valid_out, expand_ready_out}, '0);
    clear_logs();
    step(); step();
    rst_in = 1'b1;
    repeat (10) step();
    check("t6_no_stale_emit", em_v.size(), 0);
    check("t6_no_reads", rd_addr.size(), 0);
    start_search(32'd3);
    wait_ready("t6");
    check_run("t6", 27, 3, 10, 2, 3);
    check("t6_hops", hops_out, 1);
    converge_done("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
